// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int DEF_MEM_BYTES    = 64;
  localparam int DEF_STARVE_LIMIT = 4;

  // Word-aligned and inside the RAM (last valid word starts at mem_bytes-4).
  function automatic logic addr_ok(input logic [31:0] addr, input int mem_bytes);
    return (addr[1:0] == 2'b00) && (addr <= 32'(mem_bytes - 4));
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Winner select for the shared RAM port: the data port has priority unless
// fetch has lost STARVE_LIMIT arbitrations in a row.
module ram_arb_pick
  import ram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic CLK,
  input  logic Reset,
  input  logic i_req,
  input  logic d_req,
  input  logic sample,
  output logic grant,
  output logic grant_id
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          i_forced;

  // Combinational winner; fetch is forced through once the guard saturates.
  always_comb begin
    i_forced = i_req && (starve_cnt == LIMIT);
    grant    = i_req || d_req;
    grant_id = (d_req && !i_forced) ? PORT_D : PORT_I;
  end

  // Count consecutive fetch losses, cleared whenever fetch is granted.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      starve_cnt <= '0;
    end else if (sample && grant) begin
      if (grant_id == PORT_I)
        starve_cnt <= '0;
      else if (i_req && (starve_cnt != LIMIT))
        starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single data-RAM port between instruction fetch and load/store.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | sample requests, latch the winner and its address/data
// ACCESS | drive the RAM strobe for one cycle, capture read data
// RESP   | one-cycle ack (with err) to the winning requester
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int MEM_BYTES    = DEF_MEM_BYTES,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] ram_Address,
  output logic [31:0] ram_writeData,
  output logic        ram_Read,
  output logic        ram_Write,
  input  logic [31:0] ram_dataOut,
  output logic        busy
);

  state_t      state, next_state;
  logic        sample, grant, grant_id;
  logic [31:0] pick_addr, pick_wdata;
  logic        pick_we, pick_ok;
  logic        win_id, lat_we, lat_err;
  logic [31:0] lat_addr, lat_wdata;
  logic [31:0] i_rdata_q, d_rdata_q;
  logic        in_access, in_resp;

  assign sample = (state == IDLE);

  ram_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .CLK      (CLK),
    .Reset    (Reset),
    .i_req    (i_req),
    .d_req    (d_req),
    .sample   (sample),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Mux the winning requester's transaction fields; fetch never writes.
  always_comb begin
    pick_addr  = (grant_id == PORT_D) ? d_addr : i_addr;
    pick_we    = (grant_id == PORT_D) && d_we;
    pick_wdata = (grant_id == PORT_D) ? d_wdata : 32'd0;
    pick_ok    = addr_ok(pick_addr, MEM_BYTES);
  end

  // State register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state; bad addresses skip the RAM and answer straight away.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant) next_state = pick_ok ? ACCESS : RESP;
      ACCESS:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latch the granted transaction at the IDLE sample.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      win_id    <= PORT_I;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (sample && grant) begin
      win_id    <= grant_id;
      lat_we    <= pick_we;
      lat_err   <= !pick_ok;
      lat_addr  <= pick_addr;
      lat_wdata <= pick_wdata;
    end
  end

  // Capture read data at the end of ACCESS; stores leave rdata untouched.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (in_access && !lat_we) begin
      if (win_id == PORT_D) d_rdata_q <= ram_dataOut;
      else                  i_rdata_q <= ram_dataOut;
    end
  end

  // Moore outputs: RAM drive only in ACCESS, acks only in RESP.
  always_comb begin
    in_access     = (state == ACCESS);
    in_resp       = (state == RESP);
    ram_Address   = in_access ? lat_addr  : 32'd0;
    ram_writeData = in_access ? lat_wdata : 32'd0;
    ram_Read      = in_access && !lat_we;
    ram_Write     = in_access && lat_we;
    i_ack         = in_resp && (win_id == PORT_I);
    d_ack         = in_resp && (win_id == PORT_D);
    i_err         = i_ack && lat_err;
    d_err         = d_ack && lat_err;
    i_rdata       = i_rdata_q;
    d_rdata       = d_rdata_q;
    busy          = (state != IDLE);
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: behavioural big-endian RAM plus an ack scoreboard.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ack, i_err, d_ack, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic [31:0] ram_Address, ram_writeData, ram_dataOut;
  logic        ram_Read, ram_Write, busy;

  always #5 CLK = ~CLK;

  ram_port_arbiter #(.MEM_BYTES(64), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .Reset(Reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .ram_Address(ram_Address), .ram_writeData(ram_writeData),
    .ram_Read(ram_Read), .ram_Write(ram_Write), .ram_dataOut(ram_dataOut),
    .busy(busy)
  );

  // Behavioural RAM: commits on negedge, combinational big-endian read.
  logic [7:0]  mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [5:0]  ra;
  logic [5:0]  wa;
  assign ra = ram_Address[5:0];
  assign wa = ram_Write ? ram_Address[5:0] : pre_addr;
  assign ram_dataOut = ram_Read ? {mem[ra], mem[ra+6'd1], mem[ra+6'd2], mem[ra+6'd3]} : 32'hz;

  always @(negedge CLK) begin
    if (ram_Write || pre_we) begin
      mem[wa]      <= ram_Write ? ram_writeData[31:24] : pre_data[31:24];
      mem[wa+6'd1] <= ram_Write ? ram_writeData[23:16] : pre_data[23:16];
      mem[wa+6'd2] <= ram_Write ? ram_writeData[15:8]  : pre_data[15:8];
      mem[wa+6'd3] <= ram_Write ? ram_writeData[7:0]   : pre_data[7:0];
    end
  end

  function automatic logic [31:0] rd_word(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  typedef struct {
    logic        port;
    logic        keep;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0, bad = 0;
  int          cyc = 0, ack_cnt = 0, last_ack_cyc = 0, busy_low = 0;
  int          strobe_cnt = 0, addr_viol = 0;
  int          d_ack_cycs[$];
  logic [31:0] mdl_rdata [2];
  exp_t        mon_e;
  logic        mon_p;
  logic [31:0] mon_x;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Ack monitor: pops the scoreboard and checks port, data and error flag.
  always begin
    @(posedge CLK);
    #1;
    cyc++;
    if (Reset) begin
      mdl_rdata[0] = '0;
      mdl_rdata[1] = '0;
    end else begin
      if (!busy) busy_low++;
      if (i_ack || d_ack) begin
        chk("one_ack", 32'(i_ack & d_ack), 32'd0);
        chk("ack_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          mon_p = d_ack;
          mon_x = mon_e.keep ? mdl_rdata[mon_p] : mon_e.data;
          chk("ack_port", 32'(mon_p), 32'(mon_e.port));
          chk(mon_p ? "d_rdata" : "i_rdata", mon_p ? d_rdata : i_rdata, mon_x);
          chk(mon_p ? "d_err" : "i_err", 32'(mon_p ? d_err : i_err), 32'(mon_e.err));
          mdl_rdata[mon_p] = mon_x;
        end
        ack_cnt++;
        last_ack_cyc = cyc;
        if (d_ack) d_ack_cycs.push_back(cyc);
      end
    end
  end

  // Strobe counter and idle-address watch.
  always @(negedge CLK) begin
    if (ram_Read || ram_Write) strobe_cnt++;
    else if (ram_Address != 32'd0) addr_viol++;
  end

  task automatic preload(input logic [5:0] a, input logic [31:0] w);
    pre_addr = a;
    pre_data = w;
    pre_we   = 1'b1;
    @(negedge CLK);
    #1;
    pre_we   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_acks(input int target, input int limit, input string tag);
    int n = 0;
    while (ack_cnt < target && n < limit) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(ack_cnt >= target), 32'd1);
  endtask

  task automatic push_exp(input logic port, input logic keep, input logic [31:0] data, input logic err);
    exp_t e;
    e.port = port;
    e.keep = keep;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic do_req(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic keep, input logic [31:0] edata,
                        input logic err, input int lat, input string tag);
    int c0, base;
    push_exp(port, keep, edata, err);
    base = ack_cnt;
    c0   = cyc;
    if (port == PORT_D) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    wait_acks(base + 1, 20, {tag, "_timeout"});
    d_req = 1'b0;
    i_req = 1'b0;
    chk({tag, "_lat"}, 32'(last_ack_cyc - c0), 32'(lat));
    idle(2);
  endtask

  initial begin
    int base, c0, bl0, s0;
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int base, c0, bl0, s0;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    Reset = 1'b1;
    preload(6'd8,  32'h11223344);
    preload(6'd16, 32'h00000000);
    preload(6'd32, 32'h01020304);
    preload(6'd60, 32'hA5A55A5A);

    chk("rst_busy",  32'(busy), 0);
    chk("rst_acks",  32'({i_ack, d_ack, i_err, d_err}), 0);
    chk("rst_strb",  32'({ram_Read, ram_Write}), 0);
    chk("rst_addr",  ram_Address, 0);
    chk("rst_wdata", ram_writeData, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    @(negedge CLK);
    Reset = 1'b0;
    idle(2);

    // single load; the scoreboard port check also proves i_ack stays low
    do_req(PORT_D, 1'b0, 32'd8, 32'd0, 1'b0, 32'h11223344, 1'b0, 2, "ld08");

    // store then fetch, big-endian byte order in RAM
    do_req(PORT_D, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0, 2, "st10");
    chk("b10", 32'(mem[16]), 32'hDE);
    chk("b11", 32'(mem[17]), 32'hAD);
    chk("b12", 32'(mem[18]), 32'hBE);
    chk("b13", 32'(mem[19]), 32'hEF);
    do_req(PORT_I, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF, 1'b0, 2, "if10");

    // errors: misaligned, off the end, and the last valid word
    s0 = strobe_cnt;
    do_req(PORT_D, 1'b0, 32'h06, 32'd0, 1'b1, 32'd0, 1'b1, 1, "ld06");
    do_req(PORT_I, 1'b0, 32'h3D, 32'd0, 1'b1, 32'd0, 1'b1, 1, "if3d");
    do_req(PORT_D, 1'b1, 32'h40, 32'h12345678, 1'b1, 32'd0, 1'b1, 1, "st40");
    chk("err_nostrobe", 32'(strobe_cnt - s0), 0);
    do_req(PORT_I, 1'b0, 32'h3C, 32'd0, 1'b0, 32'hA5A55A5A, 1'b0, 2, "if3c");

    // back-to-back loads with d_req held
    for (int k = 0; k < 3; k++) push_exp(PORT_D, 1'b0, 32'h11223344, 1'b0);
    d_ack_cycs.delete();
    base = ack_cnt; bl0 = busy_low; c0 = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd8;
    wait_acks(base + 3, 30, "b2b_timeout");
    d_req = 1'b0;
    chk("b2b_count", 32'(d_ack_cycs.size()), 3);
    if (d_ack_cycs.size() == 3) begin
      chk("b2b_first", 32'(d_ack_cycs[0] - c0), 2);
      chk("b2b_gap1",  32'(d_ack_cycs[1] - d_ack_cycs[0]), 3);
      chk("b2b_gap2",  32'(d_ack_cycs[2] - d_ack_cycs[1]), 3);
    end
    chk("b2b_busy_low", 32'(busy_low - bl0), 2);
    idle(2);

    // contention: four data wins, then fetch, repeated
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) push_exp(PORT_I, 1'b0, 32'hA5A55A5A, 1'b0);
      else            push_exp(PORT_D, 1'b0, 32'h11223344, 1'b0);
    end
    base = ack_cnt;
    d_we = 1'b0; d_addr = 32'd8; i_addr = 32'h3C;
    d_req = 1'b1; i_req = 1'b1;
    wait_acks(base + 10, 60, "cont_timeout");
    d_req = 1'b0; i_req = 1'b0;
    idle(2);

    // reset during the ACCESS cycle of a store, before its negedge
    base = ack_cnt;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hCAFEF00D;
    @(posedge CLK);
    #2;
    chk("pre_rst_write", 32'(ram_Write), 1);
    Reset = 1'b1;
    d_req = 1'b0;
    #1;
    chk("mid_rst_strb", 32'({ram_Read, ram_Write, busy}), 0);
    chk("mid_rst_acks", 32'({i_ack, d_ack, i_err, d_err}), 0);
    chk("mid_rst_addr", ram_Address | ram_writeData, 0);
    chk("mid_rst_rdata", i_rdata | d_rdata, 0);
    idle(2);
    Reset = 1'b0;
    idle(4);
    chk("rst_mem20", rd_word(32), 32'h01020304);
    chk("rst_noack", 32'(ack_cnt - base), 0);

    chk("addr_idle_zero", 32'(addr_viol), 0);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-port arbiter and access sequencer for the byte-addressed, big-endian data RAM. It shares the single RAM port between the instruction-fetch requester and the MEM-stage load/store requester. Accesses are fixed-priority with a starvation guard for fetch. It checks word alignment and range, drives the RAM's address, read and write strobes for exactly one cycle per transaction, and returns the registered read data with a one-cycle acknowledge. It sits between the pipeline's IF/MEM stages and the RAM.

## Interface
- MEM_BYTES, 64: RAM size in bytes. Valid word addresses are 0..MEM_BYTES-4.
- STARVE_LIMIT, 4: number of consecutive lost arbitrations after which fetch wins.

- CLK  in  1  system clock; posedge logic.
- Reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  32  fetch byte address.
- i_ack  out  1  one-cycle completion pulse.
- i_rdata  out  32  fetched word; valid while i_ack is high.
- i_err  out  1  misaligned or out-of-range; valid with i_ack.
- d_req  in  1  load/store request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  load/store byte address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  32  loaded word; valid while d_ack is high.
- d_err  out  1  error flag; valid with d_ack.
- ram_Address  out  32  RAM byte address.
- ram_writeData  out  32  RAM write data.
- ram_Read  out  1  RAM read strobe.
- ram_Write  out  1  RAM write strobe; the RAM commits on negedge CLK.
- ram_dataOut  in  32  RAM combinational read data; high-Z when ram_Read=0.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: sample the requests on each posedge.
  - If neither requester is active, stay in IDLE.
  - Winner: d port, unless i_req is high and starve_cnt == STARVE_LIMIT, in which case the i port wins.
  - Latch the winner's id, address, we (always 0 for the i port) and wdata.
  - If the address is valid, go to ACCESS.
  - If addr[1:0] != 0 or addr > MEM_BYTES-4, go to RESP with err=1 and no RAM access.
- ACCESS: drive ram_Address and ram_writeData from the latches, with ram_Read = !we and ram_Write = we.
  - The store commits at the negedge inside this cycle.
  - On the next posedge, register ram_dataOut into the winner's rdata (loads and fetches only), then go to RESP.
- RESP: the winner's ack is high for this cycle only, with its rdata/err. Go to IDLE.
- starve_cnt (saturating counter):
  - Cleared when the i port is granted.
  - Incremented at each IDLE sampling where i_req=1 and the d port wins.
  - Saturates at STARVE_LIMIT.
- Store data is never returned: d_rdata holds its previous value on a store ack.
- Error response: rdata holds its previous value, and no RAM strobe is asserted.
- Requesters may change their address or data in the cycle after ack. A request still high at the next IDLE sample is treated as a new transaction.
- Simultaneous requests: exactly one is granted. The loser keeps its request pending; it is never dropped.

## Timing
- Reset values: state=IDLE, starve_cnt=0, all ack/err/Read/Write/busy = 0, all address/data outputs = 0.
- Valid access: request sampled at posedge E0; ACCESS runs E0–E1; ack is high E1–E2. Latency is 2 cycles from sample to ack, and throughput is 1 transaction per 3 cycles.
- Error access: sampled at E0, ack+err high E0–E1.
- Outside ACCESS: ram_Read=0, ram_Write=0, ram_Address=0. ram_dataOut is ignored.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; no ack is issued.
  - A store already past its negedge stays committed; a store before its negedge is not written.
- Ack is a Moore output, so there is no combinational path from req to ack.

## Structure
- Package ram_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the port-id constants PORT_I=0 and PORT_D=1;
  - the default MEM_BYTES and STARVE_LIMIT values.
- One sub-module, ram_arb_pick: combinational winner select plus the registered starve_cnt.
- The FSM, latches and RAM drive stay in the top module.

## Test plan
- Single load: RAM[8..11] preloaded with 0x11223344; d_req, d_we=0, d_addr=8 → d_ack 2 cycles after sample, d_rdata=0x11223344, d_err=0, i_ack never asserted.
- Store then fetch: d store of 0xDEADBEEF to 0x10, then i_req at 0x10 → bytes 0x10..0x13 = DE, AD, BE, EF, and i_rdata=0xDEADBEEF.
- Contention and starvation (STARVE_LIMIT=4): i_req and d_req held high continuously → the d port wins 4 times, the i port wins the 5th transaction, and the pattern repeats.
- Errors: d_addr=0x06 → d_ack+d_err 1 cycle after sample, with no RAM strobe. i_addr=0x3D (MEM_BYTES=64) → i_err=1.
- Reset mid-ACCESS: assert Reset before the negedge of a store to 0x20 → RAM[0x20..0x23] unchanged, no d_ack, all outputs 0, state IDLE.
- Back-to-back: d_req held high across 3 transactions → 3 d_acks, 3 cycles apart, and busy low only in the IDLE cycles.
